// File: rtl/gpu_pkg.sv
// Shared GPU type definitions: program-memory controller states and core
// pipeline state encodings.
package gpu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAITING  = 2'd1,
      RELAYING = 2'd2
   } mem_ctrl_state_t;

   typedef enum logic [2:0] {
      CORE_IDLE    = 3'd0,
      CORE_FETCH   = 3'd1,
      CORE_DECODE  = 3'd2,
      CORE_REQUEST = 3'd3,
      CORE_WAIT    = 3'd4,
      CORE_EXECUTE = 3'd5,
      CORE_UPDATE  = 3'd6,
      CORE_DONE    = 3'd7
   } core_state_t;

endpackage

// File: rtl/program_mem_controller_rr_arbiter.sv
// Combinational round-robin selector: first asserted request at or above
// the pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0]  request,
   input  logic [IDX_BITS-1:0] pointer,
   output logic                grant_valid,
   output logic [IDX_BITS-1:0] grant_index
);

   // Scan from the farthest offset down so the nearest request wins last.
   always_comb begin
      int idx_s;
      grant_valid = 1'b0;
      grant_index = {IDX_BITS{1'b0}};
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx_s = (int'(pointer) + k) % NUM_REQ;
         if (request[idx_s]) begin
            grant_valid = 1'b1;
            grant_index = IDX_BITS'(idx_s);
         end else begin
            grant_valid = grant_valid;
         end
      end
   end

endmodule

// File: rtl/program_mem_controller.sv
// Single-channel program memory controller shared by several instruction
// fetchers; one outstanding request, round-robin between consumers.
module program_mem_controller
   import gpu_pkg::*;
#(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 16,
   parameter int NUM_CONSUMERS = 4
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
   input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
   output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
   output logic                               mem_read_valid,
   output logic [ADDR_BITS-1:0]               mem_read_address,
   input  logic                               mem_read_ready,
   input  logic [DATA_BITS-1:0]               mem_read_data
);

   localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CONSUMERS - 1);

   mem_ctrl_state_t                    state_r, state_s;
   logic [IDX_BITS-1:0]                sel_r, sel_s;
   logic [IDX_BITS-1:0]                rr_ptr_r, rr_ptr_s;
   logic [IDX_BITS-1:0]                sel_next_ptr_s;
   logic                               mem_valid_s;
   logic [ADDR_BITS-1:0]               mem_addr_s;
   logic [NUM_CONSUMERS-1:0]           ready_s;
   logic [NUM_CONSUMERS*DATA_BITS-1:0] data_s;
   logic                               grant_valid_s;
   logic [IDX_BITS-1:0]                grant_index_s;

   rr_arbiter #(
      .NUM_REQ  (NUM_CONSUMERS),
      .IDX_BITS (IDX_BITS)
   ) u_arb (
      .request     (consumer_read_valid),
      .pointer     (rr_ptr_r),
      .grant_valid (grant_valid_s),
      .grant_index (grant_index_s)
   );

   assign sel_next_ptr_s = (sel_r == LAST_IDX) ? {IDX_BITS{1'b0}} : sel_r + IDX_BITS'(1);

   // Next-state and next-output logic; all outputs are registered below.
   always_comb begin
      state_s     = state_r;
      sel_s       = sel_r;
      rr_ptr_s    = rr_ptr_r;
      mem_valid_s = mem_read_valid;
      mem_addr_s  = mem_read_address;
      ready_s     = consumer_read_ready;
      data_s      = consumer_read_data;
      case (state_r)
         IDLE: begin
            if (grant_valid_s) begin
               sel_s       = grant_index_s;
               mem_valid_s = 1'b1;
               mem_addr_s  = consumer_read_address[grant_index_s*ADDR_BITS +: ADDR_BITS];
               state_s     = WAITING;
            end else begin
               state_s = IDLE;
            end
         end
         WAITING: begin
            if (mem_read_ready) begin
               mem_valid_s = 1'b0;
               if (consumer_read_valid[sel_r]) begin
                  data_s[sel_r*DATA_BITS +: DATA_BITS] = mem_read_data;
                  ready_s[sel_r] = 1'b1;
                  state_s        = RELAYING;
               end else begin
                  // Requester went away: drop the data and move the pointer on.
                  rr_ptr_s = sel_next_ptr_s;
                  state_s  = IDLE;
               end
            end else begin
               state_s = WAITING;
            end
         end
         RELAYING: begin
            if (!consumer_read_valid[sel_r]) begin
               ready_s  = {NUM_CONSUMERS{1'b0}};
               rr_ptr_s = sel_next_ptr_s;
               state_s  = IDLE;
            end else begin
               state_s = RELAYING;
            end
         end
         default: begin
            state_s     = IDLE;
            mem_valid_s = 1'b0;
            ready_s     = {NUM_CONSUMERS{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r             <= IDLE;
         sel_r               <= {IDX_BITS{1'b0}};
         rr_ptr_r            <= {IDX_BITS{1'b0}};
         mem_read_valid      <= 1'b0;
         mem_read_address    <= {ADDR_BITS{1'b0}};
         consumer_read_ready <= {NUM_CONSUMERS{1'b0}};
         consumer_read_data  <= {(NUM_CONSUMERS*DATA_BITS){1'b0}};
      end else begin
         state_r             <= state_s;
         sel_r               <= sel_s;
         rr_ptr_r            <= rr_ptr_s;
         mem_read_valid      <= mem_valid_s;
         mem_read_address    <= mem_addr_s;
         consumer_read_ready <= ready_s;
         consumer_read_data  <= data_s;
      end
   end

endmodule
